// File: rtl/bnn_load_pkg.sv
// Purpose : shared types and helpers for the serial image/weight load path.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package bnn_load_pkg;

    // Top-level load sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    // Default deserialized word width.
    localparam int DEF_WORD_W = 8;

    // Width of a counter that must reach 'bits' inclusive.
    function automatic int cnt_w(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/serial_load_ctrl_ser_chan.sv
// Purpose : one serial channel; counts bits, deserializes LSB-first into WORD_W words.
// Latency : completing sample -> valid one cycle later (word registered at that edge).
// Backpr. : single holding register; a word completing while it is full and not
//           being accepted is dropped and ovr_pulse fires for one cycle.
// Ports   : clear  - zero counters/shift state (load start)
//           sample - bit strobe, already qualified by the FSM being in LOAD
//           bit_in - serial bit; word/valid/ready - output handshake
//           ovr_pulse - a completed word was dropped this cycle
//           chan_done - all BITS collected and holding register empty
module ser_chan
    import bnn_load_pkg::*;
#(
    parameter int BITS   = 784,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              sample,
    input  logic              bit_in,
    input  logic              ready,
    output logic [WORD_W-1:0] word,
    output logic              valid,
    output logic              ovr_pulse,
    output logic              chan_done
);

    localparam int CW = cnt_w(BITS);
    localparam int FW = $clog2(WORD_W);

    logic [CW-1:0]     cnt;
    logic [FW-1:0]     fill;     // bits already in sreg for the current word
    logic [WORD_W-1:0] sreg;

    logic              take;
    logic              last_bit;
    logic              complete;
    logic              accept;
    logic [WORD_W-1:0] word_nxt;

    always_comb begin
        take      = sample && (cnt != CW'(BITS));
        last_bit  = (cnt == CW'(BITS - 1));
        complete  = take && ((fill == FW'(WORD_W - 1)) || last_bit);
        // Partial final words come out zero-padded because sreg is cleared
        // after every completed word.
        word_nxt  = sreg | (WORD_W'(bit_in) << fill);
        accept    = valid && ready;
        ovr_pulse = complete && valid && !ready;
        chan_done = (cnt == CW'(BITS)) && !valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            fill  <= '0;
            sreg  <= '0;
            word  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            fill  <= '0;
            sreg  <= '0;
            valid <= 1'b0;
        end else begin
            if (take) begin
                cnt <= cnt + 1'b1;
                if (complete) begin
                    sreg <= '0;
                    fill <= '0;
                end else begin
                    sreg <= word_nxt;
                    fill <= fill + 1'b1;
                end
            end
            // A word completing in the same cycle the old one is accepted
            // replaces it directly, so valid never drops in between.
            if (complete && (!valid || ready)) begin
                word  <= word_nxt;
                valid <= 1'b1;
            end else if (accept) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_load_ctrl.sv
// Purpose : sequences a two-channel (pixel/weight) serial load into WORD_W words.
// Latency : strobe rising edge seen at clk -> word valid on the next cycle.
// Backpr. : per-channel valid/ready with one holding register; dropped words set
//           sticky overrun, the load itself never stalls.
// Ports   : start - level, begins a load from IDLE/DONE
//           sync_sclk/sync_p/sync_w - synchronized strobe and data bits
//           pix_*/wgt_* - word handshakes; busy (LOAD), done (DONE), overrun (sticky)
module serial_load_ctrl
    import bnn_load_pkg::*;
#(
    parameter int PIX_BITS = 784,
    parameter int WGT_BITS = 784,
    parameter int WORD_W   = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              sync_sclk,
    input  logic              sync_p,
    input  logic              sync_w,
    output logic [WORD_W-1:0] pix_word,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [WORD_W-1:0] wgt_word,
    output logic              wgt_valid,
    input  logic              wgt_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    load_state_t state;
    logic        sclk_q;
    logic        sclk_edge;
    logic        clear;
    logic        sample;
    logic        pix_ovr;
    logic        wgt_ovr;
    logic        pix_done;
    logic        wgt_done;

    always_comb begin
        sclk_edge = sync_sclk & ~sclk_q;
        clear     = start && ((state == IDLE) || (state == DONE));
        sample    = sclk_edge && (state == LOAD);
    end

    ser_chan #(.BITS(PIX_BITS), .WORD_W(WORD_W)) u_pix (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .sample    (sample),
        .bit_in    (sync_p),
        .ready     (pix_ready),
        .word      (pix_word),
        .valid     (pix_valid),
        .ovr_pulse (pix_ovr),
        .chan_done (pix_done)
    );

    ser_chan #(.BITS(WGT_BITS), .WORD_W(WORD_W)) u_wgt (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .sample    (sample),
        .bit_in    (sync_w),
        .ready     (wgt_ready),
        .word      (wgt_word),
        .valid     (wgt_valid),
        .ovr_pulse (wgt_ovr),
        .chan_done (wgt_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sclk_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sclk_q <= sync_sclk;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        overrun <= 1'b0;
                    end
                end
                LOAD: begin
                    overrun <= overrun | pix_ovr | wgt_ovr;
                    // Channel done flags already include "holding register
                    // empty", so no word can still be in flight here.
                    if (pix_done && wgt_done) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Purpose : randomized self-checking bench for serial_load_ctrl (two parameter sets).
// Latency : compares every cycle, 1 time unit after the rising clock edge.
// Backpr. : drives pix_ready/wgt_ready directed or randomly per cycle.
module tb_serial_load_ctrl;

    localparam int WW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic sync_sclk = 1'b0;
    logic sync_p = 1'b0;
    logic sync_w = 1'b0;
    logic pix_ready = 1'b0;
    logic wgt_ready = 1'b0;

    logic [1:0][WW-1:0] pw;
    logic [1:0][WW-1:0] ww;
    logic [1:0]         pv;
    logic [1:0]         wv;
    logic [1:0]         bsy;
    logic [1:0]         dn;
    logic [1:0]         ovr;

    always #5 clk = ~clk;

    // Instance 0: PIX 12 / WGT 16; instance 1: PIX 16 (exact multiple) / WGT 16.
    serial_load_ctrl #(.PIX_BITS(12), .WGT_BITS(16), .WORD_W(WW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .sync_sclk(sync_sclk),
        .sync_p(sync_p), .sync_w(sync_w),
        .pix_word(pw[0]), .pix_valid(pv[0]), .pix_ready(pix_ready),
        .wgt_word(ww[0]), .wgt_valid(wv[0]), .wgt_ready(wgt_ready),
        .busy(bsy[0]), .done(dn[0]), .overrun(ovr[0])
    );

    serial_load_ctrl #(.PIX_BITS(16), .WGT_BITS(16), .WORD_W(WW)) dut_x16 (
        .clk(clk), .reset_n(reset_n), .start(start), .sync_sclk(sync_sclk),
        .sync_p(sync_p), .sync_w(sync_w),
        .pix_word(pw[1]), .pix_valid(pv[1]), .pix_ready(pix_ready),
        .wgt_word(ww[1]), .wgt_valid(wv[1]), .wgt_ready(wgt_ready),
        .busy(bsy[1]), .done(dn[1]), .overrun(ovr[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // State codes: 0 idle, 1 loading, 2 done.
    int         tgt[2][2] = '{'{12, 16}, '{16, 16}};
    int         m_state[2];
    bit         m_sq;
    bit         mb[2][2][32];     // every bit received this load, in order
    int         m_cnt[2][2];
    bit         m_hv[2][2];
    logic [7:0] m_hw[2][2];
    bit         m_ovr[2];

    logic [7:0] got_p[$];
    logic [7:0] got_w[$];
    logic [7:0] got_p16[$];
    bit         rnd_ready = 1'b0;

    // Word holding the most recent bits: from the last WW boundary up to n.
    function automatic logic [7:0] pack(input int i, input int c);
        int n = m_cnt[i][c];
        int base = ((n - 1) / WW) * WW;
        logic [7:0] w = '0;
        for (int k = base; k < n; k++) w[k - base] = mb[i][c][k];
        return w;
    endfunction

    task automatic model_step();
        bit edge_s;
        bit fin;
        bit rdy;
        bit bi;
        bit acc;
        bit comp;
        if (!reset_n) begin
            m_sq = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_state[i] = 0;
                m_ovr[i] = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    m_cnt[i][c] = 0; m_hv[i][c] = 1'b0; m_hw[i][c] = '0;
                end
            end
            return;
        end
        edge_s = sync_sclk && !m_sq;
        for (int i = 0; i < 2; i++) begin
            if (m_state[i] != 1) begin
                if (start) begin
                    m_state[i] = 1;
                    m_ovr[i] = 1'b0;
                    for (int c = 0; c < 2; c++) begin
                        m_cnt[i][c] = 0; m_hv[i][c] = 1'b0;
                    end
                end
            end else begin
                fin = m_cnt[i][0] == tgt[i][0] && m_cnt[i][1] == tgt[i][1]
                      && !m_hv[i][0] && !m_hv[i][1];
                for (int c = 0; c < 2; c++) begin
                    rdy  = (c == 0) ? pix_ready : wgt_ready;
                    bi   = (c == 0) ? sync_p : sync_w;
                    acc  = m_hv[i][c] && rdy;
                    comp = 1'b0;
                    if (edge_s && m_cnt[i][c] < tgt[i][c]) begin
                        mb[i][c][m_cnt[i][c]] = bi;
                        m_cnt[i][c]++;
                        comp = (m_cnt[i][c] % WW == 0) || (m_cnt[i][c] == tgt[i][c]);
                    end
                    if (comp) begin
                        if (!m_hv[i][c] || acc) begin
                            m_hv[i][c] = 1'b1;
                            m_hw[i][c] = pack(i, c);
                        end else begin
                            m_ovr[i] = 1'b1;
                        end
                    end else if (acc) begin
                        m_hv[i][c] = 1'b0;
                    end
                end
                if (fin) m_state[i] = 2;
            end
        end
        m_sq = sync_sclk;
    endtask

    // One clock: advance model with current inputs, record handshakes, compare.
    task automatic step();
        if (rnd_ready) begin
            pix_ready = 1'($urandom_range(0, 1));
            wgt_ready = 1'($urandom_range(0, 1));
        end
        model_step();
        if (pv[0] && pix_ready) got_p.push_back(pw[0]);
        if (wv[0] && wgt_ready) got_w.push_back(ww[0]);
        if (pv[1] && pix_ready) got_p16.push_back(pw[1]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.pix_valid", i), 32'(pv[i]), 32'(m_hv[i][0]));
            chk($sformatf("u%0d.pix_word", i), 32'(pw[i]), 32'(m_hw[i][0]));
            chk($sformatf("u%0d.wgt_valid", i), 32'(wv[i]), 32'(m_hv[i][1]));
            chk($sformatf("u%0d.wgt_word", i), 32'(ww[i]), 32'(m_hw[i][1]));
            chk($sformatf("u%0d.busy", i), 32'(bsy[i]), 32'(m_state[i] == 1));
            chk($sformatf("u%0d.done", i), 32'(dn[i]), 32'(m_state[i] == 2));
            chk($sformatf("u%0d.overrun", i), 32'(ovr[i]), 32'(m_ovr[i]));
        end
    endtask

    task automatic send_edge(input logic p, input logic w);
        sync_p = p;
        sync_w = w;
        sync_sclk = 1'b1;
        step();
        sync_sclk = 1'b0;
        // Data wiggles while the strobe is low must not be sampled.
        sync_p = 1'($urandom_range(0, 1));
        sync_w = 1'($urandom_range(0, 1));
        repeat (1 + $urandom_range(0, 1)) step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_got();
        got_p.delete();
        got_w.delete();
        got_p16.delete();
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && !(dn[0] && dn[1]); k++) step();
        chk("reach_done", 32'(dn[0] && dn[1]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pbits;
        logic [15:0] wbits;

        // Reset state.
        step();
        chk("rst_pix_valid", 32'(pv[0]), 32'd0);
        reset_n = 1'b1;
        step();

        // Basic load, consumers always ready. Pixel bits 1,0,1,1,0,0,0,0,1,1,1,1
        // then four extra 1s (only the 16-bit instance uses them).
        pix_ready = 1'b1;
        wgt_ready = 1'b1;
        pbits = 16'hFF0D;
        clear_got();
        do_start();
        for (int e = 0; e < 16; e++) send_edge(pbits[e], 1'b1);
        wait_done();
        chk("basic_npix", 32'(got_p.size()), 32'd2);
        if (got_p.size() == 2) begin
            chk("basic_pix0", 32'(got_p[0]), 32'h0D);
            chk("basic_pix1", 32'(got_p[1]), 32'h0F);
        end
        chk("basic_nwgt", 32'(got_w.size()), 32'd2);
        if (got_w.size() == 2) begin
            chk("basic_wgt0", 32'(got_w[0]), 32'hFF);
            chk("basic_wgt1", 32'(got_w[1]), 32'hFF);
        end
        chk("x16_npix", 32'(got_p16.size()), 32'd2);
        if (got_p16.size() == 2) chk("x16_pix1", 32'(got_p16[1]), 32'hFF);
        chk("basic_ovr", 32'(ovr[0]), 32'd0);

        // Backpressure: ready low until the cycle the final pixel word completes.
        pix_ready = 1'b0;
        clear_got();
        do_start();
        for (int e = 0; e < 16; e++) begin
            if (e == 11) pix_ready = 1'b1;
            send_edge(pbits[e], 1'b0);
        end
        wait_done();
        chk("bp_npix", 32'(got_p.size()), 32'd2);
        if (got_p.size() == 2) chk("bp_pix1", 32'(got_p[1]), 32'h0F);
        chk("bp_ovr", 32'(ovr[0]), 32'd0);

        // Overrun: pixel ready low for the whole load.
        pix_ready = 1'b0;
        clear_got();
        do_start();
        for (int e = 0; e < 16; e++) send_edge(pbits[e], 1'($urandom_range(0, 1)));
        pix_ready = 1'b1;
        wait_done();
        chk("ovr_set", 32'(ovr[0]), 32'd1);
        chk("ovr_npix", 32'(got_p.size()), 32'd1);
        if (got_p.size() == 1) chk("ovr_pix0", 32'(got_p[0]), 32'h0D);
        do_start();
        chk("ovr_cleared", 32'(ovr[0]), 32'd0);
        for (int e = 0; e < 16; e++) send_edge(pbits[e], 1'b1);
        wait_done();

        // Asynchronous reset mid-load with a pixel word held.
        pix_ready = 1'b0;
        do_start();
        for (int e = 0; e < 8; e++) send_edge(pbits[e], 1'b1);
        chk("pre_rst_valid", 32'(pv[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("arst%0d.outs", i),
                {pw[i], ww[i], 8'(pv[i]), 8'({wv[i], bsy[i], dn[i], ovr[i]})}, 32'd0);
        end
        step();
        reset_n = 1'b1;
        pix_ready = 1'b1;
        for (int e = 0; e < 8; e++) send_edge(1'b1, 1'b1);
        chk("post_rst_idle", 32'(pv[0] | wv[0] | bsy[0]), 32'd0);

        // Randomized loads: random data, random ready, stray start pulses,
        // and start held high across DONE.
        rnd_ready = 1'b1;
        for (int ld = 0; ld < 8; ld++) begin
            pbits = 16'($urandom);
            wbits = 16'($urandom);
            clear_got();
            if (!(ld > 0 && dn[0] && start)) do_start();
            start = 1'b0;
            for (int e = 0; e < 18; e++) begin
                if (e == 5) start = 1'b1;
                send_edge(pbits[e % 16], wbits[e % 16]);
                start = 1'b0;
            end
            wait_done();
            if (ld % 2 == 1) begin
                start = 1'b1;
                step();
                step();
            end
        end
        start = 1'b0;
        rnd_ready = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
